// File: rtl/run_end_detector.sv
// run_end_detector
//   Watches the serial bit stream x_in for a run of at least min_run
//   consecutive 1s, then flags the 0 that ends that run. A min_run of 0 is
//   treated as 1. The detection pulse is either combinational (Mealy,
//   REG_OUT=0) or registered (REG_OUT=1, one cycle later).
//
// Parameters
//   CNT_W    width of run_len and min_run; run_len saturates at 2^CNT_W-1
//   DET_W    width of det_count; saturates at 2^DET_W-1
//   REG_OUT  0 = combinational y_out, 1 = registered y_out
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   en         sample enable; when low the run state and counter hold
//   x_in       serial data bit
//   min_run    required run length (live, not latched)
//   clr_stats  synchronous clear of det_count (wins over a simultaneous detect)
//   y_out      detection pulse
//   run_len    consecutive 1s accepted so far
//   run_active run_len != 0
//   det_count  detections since reset or last clear
module run_end_detector #(
  parameter int CNT_W   = 4,
  parameter int DET_W   = 8,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x_in,
  input  logic [CNT_W-1:0] min_run,
  input  logic             clr_stats,
  output logic             y_out,
  output logic [CNT_W-1:0] run_len,
  output logic             run_active,
  output logic [DET_W-1:0] det_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [DET_W-1:0] DET_MAX = '1;

  logic [CNT_W-1:0] run_len_reg, run_len_next;
  logic [DET_W-1:0] det_count_reg, det_count_next;
  logic [CNT_W-1:0] eff_min;
  state_t           state;
  logic             det;

  // State register: the run length counter is the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_len_reg   <= '0;
      det_count_reg <= '0;
    end else begin
      run_len_reg   <= run_len_next;
      det_count_reg <= det_count_next;
    end
  end

  // Classification is redone every cycle against the live threshold, so a
  // min_run change mid-run moves the state between RUN and ARMED at once.
  always_comb begin
    eff_min        = (min_run == '0) ? CNT_W'(1) : min_run;
    state          = IDLE;
    det            = 1'b0;
    run_len_next   = run_len_reg;
    det_count_next = det_count_reg;

    if (run_len_reg == '0)
      state = IDLE;
    else if (run_len_reg >= eff_min)
      state = ARMED;
    else
      state = RUN;

    if (en) begin
      case (state)
        IDLE: begin
          if (x_in)
            run_len_next = CNT_W'(1);
        end
        RUN: begin
          if (x_in)
            run_len_next = run_len_reg + CNT_W'(1);
          else
            run_len_next = '0;
        end
        ARMED: begin
          if (x_in) begin
            if (run_len_reg != RUN_MAX)
              run_len_next = run_len_reg + CNT_W'(1);
          end else begin
            det          = 1'b1;
            run_len_next = '0;
          end
        end
        default: run_len_next = '0;
      endcase
    end

    // Clear is a control operation, not a sample: it applies whether or not
    // en is high, and overrides a detect on the same edge.
    if (clr_stats)
      det_count_next = '0;
    else if (det && (det_count_reg != DET_MAX))
      det_count_next = det_count_reg + DET_W'(1);
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic y_reg;
      // Loads det every edge (0 while en is low), giving a one-cycle pulse.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          y_reg <= 1'b0;
        else
          y_reg <= det;
      end
      assign y_out = y_reg;
    end else begin : g_comb_out
      assign y_out = det;
    end
  endgenerate

  assign run_len    = run_len_reg;
  assign run_active = (run_len_reg != '0);
  assign det_count  = det_count_reg;

endmodule

// File: tb/tb_run_end_detector.sv
// Bench for run_end_detector. Two instances share all inputs:
//   dut0: REG_OUT=0, DET_W=8 (Mealy output, wide counter)
//   dut1: REG_OUT=1, DET_W=2 (registered output, counter saturates at 3)
// Each stimulus bit pushes the hand-computed values expected at the
// following negedge (run_len before the bit is absorbed, both y_out values,
// both det_counts); the monitor pops and compares on every negedge.
module tb_run_end_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       x_in = 1'b0;
  logic [3:0] min_run = 4'd0;
  logic       clr_stats = 1'b0;

  logic       y0, y1, act0, act1;
  logic [3:0] rl0, rl1;
  logic [7:0] dc0;
  logic [1:0] dc1;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  typedef struct {
    logic [3:0] rl;
    logic       y0;
    logic       y1;
    logic [7:0] dc0;
    logic [1:0] dc1;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  run_end_detector #(.CNT_W(4), .DET_W(8), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .min_run(min_run),
    .clr_stats(clr_stats), .y_out(y0), .run_len(rl0), .run_active(act0),
    .det_count(dc0)
  );

  run_end_detector #(.CNT_W(4), .DET_W(2), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .min_run(min_run),
    .clr_stats(clr_stats), .y_out(y1), .run_len(rl1), .run_active(act1),
    .det_count(dc1)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares on every negedge for which a transaction is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d x=%0b en=%0b min=%0d clr=%0b | rl=%0d y0=%0b y1=%0b dc0=%0d dc1=%0d",
                 txn, x_in, en, min_run, clr_stats, rl0, y0, y1, dc0, dc1);
        chk("run_len", int'(rl0), int'(e.rl));
        chk("run_len_dut1", int'(rl1), int'(e.rl));
        chk("run_active", int'(act0), int'(e.rl != 4'd0));
        chk("y_out_mealy", int'(y0), int'(e.y0));
        chk("y_out_reg", int'(y1), int'(e.y1));
        chk("det_count_w8", int'(dc0), int'(e.dc0));
        chk("det_count_w2", int'(dc1), int'(e.dc1));
      end
    end
  end

  // Drive one bit at posedge+1, queue its expectation, advance one cycle.
  task automatic step(input int x, input int e_n, input int mr, input int clr,
                      input int rl, input int ey0, input int ey1,
                      input int edc0, input int edc1);
    exp_t e;
    x_in      = 1'(x);
    en        = 1'(e_n);
    min_run   = 4'(mr);
    clr_stats = 1'(clr);
    e.rl  = 4'(rl);
    e.y0  = 1'(ey0);
    e.y1  = 1'(ey1);
    e.dc0 = 8'(edc0);
    e.dc1 = 2'(edc1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    x_in = 1'b0; en = 1'b0; clr_stats = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    chk("reset_run_len", int'(rl0), 0);
    chk("reset_y_out_mealy", int'(y0), 0);
    chk("reset_y_out_reg", int'(y1), 0);
    chk("reset_det_count", int'(dc0), 0);
    rst = 1'b1;

    // A: min_run=3, x=1,1,0,1,1,1,0 -> detect only on 7th bit
    step(1,1,3,0, 0,0,0,0,0);
    step(1,1,3,0, 1,0,0,0,0);
    step(0,1,3,0, 2,0,0,0,0);
    step(1,1,3,0, 0,0,0,0,0);
    step(1,1,3,0, 1,0,0,0,0);
    step(1,1,3,0, 2,0,0,0,0);
    step(0,1,3,0, 3,1,0,0,0);
    step(0,1,3,0, 0,0,1,1,1);
    step(0,1,3,0, 0,0,0,1,1);

    // Async reset mid-run: build run_len=5, then drop rst between edges
    step(1,1,3,0, 0,0,0,1,1);
    step(1,1,3,0, 1,0,0,1,1);
    step(1,1,3,0, 2,0,0,1,1);
    step(1,1,3,0, 3,0,0,1,1);
    step(1,1,3,0, 4,0,0,1,1);
    x_in = 1'b0;
    #1;
    chk("pre_reset_run_len", int'(rl0), 5);
    chk("pre_reset_y_out_mealy", int'(y0), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_run_len", int'(rl0), 0);
    chk("async_reset_run_active", int'(act0), 0);
    chk("async_reset_det_count_w8", int'(dc0), 0);
    chk("async_reset_det_count_w2", int'(dc1), 0);
    chk("async_reset_y_out_mealy", int'(y0), 0);
    chk("async_reset_y_out_reg", int'(y1), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // B: min_run=0 (acts as 1), x=1,0,0,1,0 -> two detections
    do_reset();
    step(1,1,0,0, 0,0,0,0,0);
    step(0,1,0,0, 1,1,0,0,0);
    step(0,1,0,0, 0,0,1,1,1);
    step(1,1,0,0, 0,0,0,1,1);
    step(0,1,0,0, 1,1,0,1,1);
    step(0,1,0,0, 0,0,1,2,2);

    // C: saturation, min_run=15, twenty 1s then a 0
    do_reset();
    for (int i = 1; i <= 20; i++)
      step(1,1,15,0, (i - 1 > 15) ? 15 : i - 1, 0,0,0,0);
    step(0,1,15,0, 15,1,0,0,0);
    step(0,1,15,0, 0,0,1,1,1);

    // D: enable gap, min_run=1
    do_reset();
    step(1,1,1,0, 0,0,0,0,0);
    step(0,0,1,0, 1,0,0,0,0);
    step(0,0,1,0, 1,0,0,0,0);
    step(0,0,1,0, 1,0,0,0,0);
    step(0,1,1,0, 1,1,0,0,0);
    step(0,1,1,0, 0,0,1,1,1);

    // E: stats saturation (dut1 at 3) and clear beating a detect
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1,1,1,0, 0,0,(k > 0) ? 1 : 0, k, (k > 3) ? 3 : k);
      step(0,1,1,0, 1,1,0, k, (k > 3) ? 3 : k);
    end
    step(1,1,1,0, 0,0,1,4,3);
    step(0,1,1,1, 1,1,0,4,3);
    step(0,1,1,0, 0,0,1,0,0);

    // F: min_run raised mid-run demotes ARMED back to RUN
    do_reset();
    step(1,1,2,0, 0,0,0,0,0);
    step(1,1,2,0, 1,0,0,0,0);
    step(1,1,2,0, 2,0,0,0,0);
    step(0,1,5,0, 3,0,0,0,0);
    step(0,1,5,0, 0,0,0,0,0);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_end_detector.md
Name: run_end_detector

Overview:
- Parametrised successor to the single-bit Mealy zero detector.
- Watches serial input x_in for a run of consecutive 1s of at least min_run bits, then flags the terminating 0.
- Output timing is selectable: Mealy (same cycle) or registered Moore-style (one cycle later).
- Also provides live run length, a saturating detection counter and a clock-enable, so one block serves all serial-line framing checks in the sequential-logic examples.

Parameters:
- CNT_W, 4, width of run_len counter and min_run threshold; run_len saturates at 2^CNT_W-1.
- DET_W, 8, width of det_count; saturates at 2^DET_W-1.
- REG_OUT, 0, 0 = Mealy combinational y_out; 1 = y_out registered (one-cycle latency).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when 0, all state holds and x_in is ignored.
- x_in  input  1  serial data bit.
- min_run  input  CNT_W  required run length; value 0 is treated as 1.
- clr_stats  input  1  synchronous clear of det_count.
- y_out  output  1  detection pulse.
- run_len  output  CNT_W  consecutive 1s accepted so far (registered).
- run_active  output  1  run_len != 0.
- det_count  output  DET_W  number of detections since reset/clear (registered).

Behaviour:
- Reset (rst=0, async): run_len=0, det_count=0, y_out=0, run_active=0, internal y register=0.
- eff_min = (min_run==0) ? 1 : min_run. Sampled live every cycle; no latching.
- Detect condition: det = en & ~x_in & (run_len >= eff_min).
- FSM (run_len is the state counter):
  - IDLE (run_len=0): x=1 -> RUN, run_len=1; x=0 -> stay IDLE.
  - RUN (0 < run_len < eff_min): x=1 -> run_len+1, move to ARMED once run_len >= eff_min; x=0 -> IDLE, no detect.
  - ARMED (run_len >= eff_min): x=1 -> run_len+1 (saturating); x=0 -> detect, run_len=0, IDLE.
- Classification is by live comparison each cycle. If min_run changes mid-run, the state reclassifies immediately: e.g. run_len=3 in ARMED with min_run 2->5 becomes RUN.
- Saturation: at run_len = 2^CNT_W-1, further 1s hold the value and the run stays ARMED if eff_min <= max. A terminating 0 still detects.
- en=0: run_len and det_count hold, det=0.
  - REG_OUT=0: y_out=0.
  - REG_OUT=1: y_out follows its register, which loads det (=0) on that edge.
- REG_OUT=0: y_out = det, combinational from x_in, en and state. It can be high only while x_in=0.
- REG_OUT=1: y_out is registered det, a single-cycle pulse on the cycle after the qualifying 0. Back-to-back detections are impossible, since a detect always clears the run.
- det_count increments by 1 on each edge where det=1, saturating at max.
  - clr_stats=1: det_count<=0; clear has priority over a simultaneous detect (result 0).
  - clr_stats has no effect on run_len or y_out.
- Reset asserted mid-run clears everything immediately. A pending REG_OUT=1 pulse is lost.
- Equivalence: with min_run=1, REG_OUT=0, en=1, the block is functionally identical to the original zero detector (output 1 on a 0 following one or more 1s).

Test Plan:
- Async reset mid-run: run_len=5, drop rst between edges -> run_len, det_count, y_out read 0 immediately, before the next clk edge.
- REG_OUT=0, min_run=3, en=1, x = 1,1,0,1,1,1,0 -> y_out high only during the 7th bit. run_len sequence 1,2,0,1,2,3,0. det_count=1.
- REG_OUT=1, min_run=0 (treated as 1), x = 1,0,0,1,0 -> y_out pulses the cycle after bit 2 and the cycle after bit 5. det_count=2.
- Saturation, CNT_W=4, min_run=15: twenty 1s then a 0 -> run_len holds 15 from the 15th bit, y_out=1 on the 0, run_len then 0.
- en gaps: x=1 en=1, then en=0 for 3 cycles with x=0, then x=0 en=1 (min_run=1) -> no detect during the gap, run_len holds 1, detect on the final bit.
- Stats, DET_W=2: 4 qualifying detections -> det_count saturates at 3. Then clr_stats=1 coincident with a detect -> det_count=0; y_out still pulses.
- min_run change: run_len=3 with min_run=2, set min_run=5, then x=0 -> no detect, run_len=0.
